// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: one requester port of alu_arbiter, request handshake plus its result slot.
interface alu_arbiter_if;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  modport master (output req_valid, req_op, req_src1, req_src2, rsp_ready,
                  input  req_ready, rsp_valid, rsp_result);
  modport slave  (input  req_valid, req_op, req_src1, req_src2, rsp_ready,
                  output req_ready, rsp_valid, rsp_result);
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one combinational ALU through a round-robin grant;
// each port owns a single result slot that refills back-to-back when drained.
module alu_arbiter #(
  parameter int unsigned RR_RESET_LAST = 1
) (
  input  logic          clk,
  input  logic          resetn,
  alu_arbiter_if.slave  p0,
  alu_arbiter_if.slave  p1,
  output logic          busy
);
  logic [1:0]  full, el, grant;
  logic        last, live;
  logic [11:0] op;
  logic [31:0] a, b, y, res0, res1;
  function automatic logic [31:0] alu(input logic [11:0] o, input logic [31:0] x, input logic [31:0] z);
    logic [31:0] r;
    r = ({32{o[0]}}  & (x + z))
      | ({32{o[1]}}  & (x - z))
      | ({32{o[2]}}  & {31'b0, $signed(x) < $signed(z)})
      | ({32{o[3]}}  & {31'b0, x < z})
      | ({32{o[4]}}  & (x & z))
      | ({32{o[5]}}  & ~(x | z))
      | ({32{o[6]}}  & (x | z))
      | ({32{o[7]}}  & (x ^ z))
      | ({32{o[8]}}  & (x << z[4:0]))
      | ({32{o[9]}}  & (x >> z[4:0]))
      | ({32{o[10]}} & 32'($signed(x) >>> z[4:0]))
      | ({32{o[11]}} & z);
    return r;
  endfunction
  assign el[0] = p0.req_valid & (~full[0] | p0.rsp_ready);
  assign el[1] = p1.req_valid & (~full[1] | p1.rsp_ready);
  // live holds off grants until the first edge after reset is released
  always_comb begin
    grant[0] = live & el[0] & (~el[1] | last);
    grant[1] = live & el[1] & (~el[0] | ~last);
    op = grant[1] ? p1.req_op   : p0.req_op;
    a  = grant[1] ? p1.req_src1 : p0.req_src1;
    b  = grant[1] ? p1.req_src2 : p0.req_src2;
    y  = alu(op, a, b);
  end
  assign p0.req_ready  = grant[0];
  assign p1.req_ready  = grant[1];
  assign p0.rsp_valid  = full[0];
  assign p1.rsp_valid  = full[1];
  assign p0.rsp_result = res0;
  assign p1.rsp_result = res1;
  assign busy = |full;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      full <= '0;
      last <= 1'(RR_RESET_LAST);
      live <= 1'b0;
      res0 <= '0;
      res1 <= '0;
    end else begin
      live    <= 1'b1;
      full[0] <= grant[0] | (full[0] & ~p0.rsp_ready);
      full[1] <= grant[1] | (full[1] & ~p1.rsp_ready);
      last    <= grant[1] ? 1'b1 : grant[0] ? 1'b0 : last;
      if (grant[0]) res0 <= y;
      if (grant[1]) res1 <= y;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench; expected results are queued at grant and compared on consume.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic busy;
  always #5 clk = ~clk;
  alu_arbiter_if p0 ();
  alu_arbiter_if p1 ();
  alu_arbiter #(.RR_RESET_LAST(1)) dut (.clk(clk), .resetn(resetn), .p0(p0), .p1(p1), .busy(busy));
  logic        v[2];
  logic        rr[2];
  logic [11:0] op[2];
  logic [31:0] sa[2];
  logic [31:0] sb[2];
  assign p0.req_valid = v[0];
  assign p0.req_op    = op[0];
  assign p0.req_src1  = sa[0];
  assign p0.req_src2  = sb[0];
  assign p0.rsp_ready = rr[0];
  assign p1.req_valid = v[1];
  assign p1.req_op    = op[1];
  assign p1.req_src1  = sa[1];
  assign p1.req_src2  = sb[1];
  assign p1.rsp_ready = rr[1];
  int checks = 0;
  int failures = 0;
  bit mfull[2];
  bit mlast = 1'b1;
  bit acc[2];
  logic [31:0] q[2][$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] alu_ref(input logic [11:0] o, input logic [31:0] x, input logic [31:0] z);
    logic [63:0] ext;
    ext = {{32{x[31]}}, x} >> z[4:0];
    case (o)
      12'h001: return x + z;
      12'h002: return x - z;
      12'h004: return ($signed(x) < $signed(z)) ? 32'd1 : 32'd0;
      12'h008: return (x < z) ? 32'd1 : 32'd0;
      12'h010: return x & z;
      12'h020: return ~(x | z);
      12'h040: return x | z;
      12'h080: return x ^ z;
      12'h100: return x << z[4:0];
      12'h200: return x >> z[4:0];
      12'h400: return ext[31:0];
      12'h800: return z;
      default: return 32'd0;
    endcase
  endfunction
  task automatic drive(input int n, input logic val, input logic [11:0] o, input logic [31:0] x, input logic [31:0] z);
    v[n] = val; op[n] = o; sa[n] = x; sb[n] = z;
  endtask
  task automatic cycle();
    logic        rv[2];
    logic        rdy[2];
    logic [31:0] res[2];
    bit          el[2];
    bit          g[2];
    @(negedge clk);
    rv[0] = p0.rsp_valid;  rv[1] = p1.rsp_valid;
    rdy[0] = p0.req_ready; rdy[1] = p1.req_ready;
    res[0] = p0.rsp_result; res[1] = p1.rsp_result;
    check("busy", {31'b0, busy}, {31'b0, mfull[0] | mfull[1]});
    for (int n = 0; n < 2; n++) begin
      check($sformatf("rsp%0d_valid", n), {31'b0, rv[n]}, {31'b0, mfull[n]});
      if (mfull[n] && q[n].size() > 0) begin
        check($sformatf("rsp%0d_result", n), res[n], q[n][0]);
        if (rr[n]) void'(q[n].pop_front());
      end
      el[n] = v[n] && (!mfull[n] || rr[n]);
    end
    if (el[0] && el[1]) begin
      g[0] = mlast; g[1] = !mlast;
    end else begin
      g[0] = el[0]; g[1] = el[1];
    end
    for (int n = 0; n < 2; n++) begin
      check($sformatf("req%0d_ready", n), {31'b0, rdy[n]}, {31'b0, g[n]});
      if (g[n]) q[n].push_back(alu_ref(op[n], sa[n], sb[n]));
      if (g[n]) mfull[n] = 1'b1;
      else if (rr[n]) mfull[n] = 1'b0;
      acc[n] = g[n];
    end
    if (g[0]) mlast = 1'b0;
    if (g[1]) mlast = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    v[0] = 1'b1; v[1] = 1'b1; rr[0] = 1'b1; rr[1] = 1'b1;
    #2 resetn = 1'b0;
    #1;
    check("rst rsp0_valid", {31'b0, p0.rsp_valid}, 32'd0);
    check("rst rsp1_valid", {31'b0, p1.rsp_valid}, 32'd0);
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst rsp0_result", p0.rsp_result, 32'd0);
    check("rst rsp1_result", p1.rsp_result, 32'd0);
    check("rst req0_ready", {31'b0, p0.req_ready}, 32'd0);
    check("rst req1_ready", {31'b0, p1.req_ready}, 32'd0);
    #1 resetn = 1'b1;
    #1;
    check("post-rst req0_ready", {31'b0, p0.req_ready}, 32'd0);
    check("post-rst req1_ready", {31'b0, p1.req_ready}, 32'd0);
    v[0] = 1'b0; v[1] = 1'b0;
    mfull[0] = 1'b0; mfull[1] = 1'b0; mlast = 1'b1;
    q[0].delete(); q[1].delete();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [11:0] sop[2][8];
    logic [31:0] s1[2][8];
    logic [31:0] s2[2][8];
    int idx[2];
    int prev;
    int k;
    int n_acc;
    for (int n = 0; n < 2; n++) begin
      v[n] = 1'b0; rr[n] = 1'b0; op[n] = '0; sa[n] = '0; sb[n] = '0;
    end
    @(posedge clk);
    #1;
    do_reset();
    // single add with overflow wrap
    rr[0] = 1'b1;
    drive(0, 1'b1, 12'h001, 32'h7FFF_FFFF, 32'h1);
    cycle();
    check("add grant", {31'b0, acc[0]}, 32'd1);
    drive(0, 1'b0, 12'h000, 32'h0, 32'h0);
    check("add result", p0.rsp_result, 32'h8000_0000);
    check("add valid T+1", {31'b0, p0.rsp_valid}, 32'd1);
    cycle();
    cycle();
    // tie after reset: port0 wins first
    do_reset();
    rr[0] = 1'b1; rr[1] = 1'b1;
    drive(0, 1'b1, 12'h004, 32'hFFFF_FFFF, 32'h1);
    drive(1, 1'b1, 12'h008, 32'hFFFF_FFFF, 32'h1);
    cycle();
    check("tie first port0", {31'b0, acc[0]}, 32'd1);
    check("slt result", p0.rsp_result, 32'd1);
    v[0] = 1'b0;
    cycle();
    check("tie second port1", {31'b0, acc[1]}, 32'd1);
    check("sltu result", p1.rsp_result, 32'd0);
    v[1] = 1'b0;
    cycle();
    // backpressure on port1
    rr[1] = 1'b0;
    drive(1, 1'b1, 12'h400, 32'h8000_0000, 32'd4);
    cycle();
    drive(1, 1'b1, 12'h001, 32'd5, 32'd6);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("sra held", p1.rsp_result, 32'hF800_0000);
      check("req1 stalled", {31'b0, acc[1]}, 32'd0);
    end
    rr[1] = 1'b1;
    cycle();
    check("req1 accepted on drain", {31'b0, acc[1]}, 32'd1);
    v[1] = 1'b0;
    cycle();
    cycle();
    // port0 streams four adds back-to-back
    rr[0] = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 12'h001, 32'(i * 1000), 32'(i + 7));
      cycle();
      if (acc[0]) n_acc++;
      check("stream valid", {31'b0, p0.rsp_valid}, 32'd1);
    end
    check("stream no bubbles", 32'(n_acc), 32'd4);
    v[0] = 1'b0;
    cycle();
    // contention: both ports stream eight ops
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < 8; i++) begin
        k = $urandom_range(0, 12);
        sop[n][i] = (k == 12) ? 12'h000 : 12'(1 << k);
        s1[n][i] = $urandom;
        s2[n][i] = $urandom;
      end
    idx[0] = 0; idx[1] = 0; prev = -1;
    rr[0] = 1'b1; rr[1] = 1'b1;
    for (int c = 0; c < 40 && (idx[0] < 8 || idx[1] < 8); c++) begin
      for (int n = 0; n < 2; n++)
        if (idx[n] < 8) drive(n, 1'b1, sop[n][idx[n]], s1[n][idx[n]], s2[n][idx[n]]);
        else v[n] = 1'b0;
      cycle();
      if (acc[0] || acc[1]) begin
        check("one grant per cycle", 32'(int'(acc[0]) + int'(acc[1])), 32'd1);
        if (prev >= 0) check("alternation", 32'(acc[1] ? 1 : 0), 32'(1 - prev));
        prev = acc[1] ? 1 : 0;
      end
      for (int n = 0; n < 2; n++) if (acc[n]) idx[n]++;
    end
    check("contention port0 count", 32'(idx[0]), 32'd8);
    check("contention port1 count", 32'(idx[1]), 32'd8);
    v[0] = 1'b0; v[1] = 1'b0;
    cycle();
    cycle();
    // fill both slots, then asynchronous reset between edges
    rr[0] = 1'b0; rr[1] = 1'b0;
    drive(0, 1'b1, 12'h040, 32'hF0, 32'h0F);
    drive(1, 1'b1, 12'h800, 32'h0, 32'h1234_0000);
    cycle();
    cycle();
    check("both full busy", {31'b0, busy}, 32'd1);
    check("slot0 full", {31'b0, p0.rsp_valid}, 32'd1);
    check("slot1 full", {31'b0, p1.rsp_valid}, 32'd1);
    do_reset();
    cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RR_RESET_LAST, default 1, index of the port treated as last-granted after reset (0 or 1).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 reqN_valid  input  1  (N = 0, 1) port N presents an ALU operation.
REQ-005 reqN_ready  output  1  port N operation accepted this cycle when reqN_valid & reqN_ready.
REQ-006 reqN_op  input  12  one-hot ALU control (bit order add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui).
REQ-007 reqN_src1, reqN_src2  input  32 each  operands.
REQ-008 rspN_valid  output  1  port N result slot holds a valid result.
REQ-009 rspN_ready  input  1  port N consumes its result when rspN_valid & rspN_ready.
REQ-010 rspN_result  output  32  port N result; stable while rspN_valid & ~rspN_ready.
REQ-011 busy  output  1  any response slot full.

Function
REQ-012 One combinational alu instance is shared; at most one request is granted per cycle.
REQ-013 Each port owns a result slot, states EMPTY/FULL; rspN_valid = (slot N == FULL).
REQ-014 Port N is eligible when reqN_valid and (slot N EMPTY, or slot N FULL and rspN_ready this cycle).
REQ-015 Only one port eligible -> that port granted.
REQ-016 Both eligible -> grant the port other than last_grant (round-robin).
REQ-017 last_grant updates to the granted port only on a grant; unchanged on idle cycles.
REQ-018 reqN_ready = grant to port N; reqN_ready never asserted while port N ineligible; ready depends combinationally on valid, slot state, rsp_ready (no combinational path from req data).
REQ-019 Latency: request granted in cycle T -> rspN_valid high and rspN_result = alu(reqN_op, reqN_src1, reqN_src2) from cycle T+1.
REQ-020 Slot transitions: EMPTY+grant -> FULL; FULL+consume+no grant -> EMPTY; FULL+consume+grant -> FULL with new result (back-to-back, full throughput per port); FULL+no consume -> FULL, result held.
REQ-021 Result register loads only on grant; otherwise retains value, including after consume.
REQ-022 Arithmetic exactly as alu: 32-bit wrap add/sub, slt signed, sltu unsigned, shifts by src2[4:0] of src1, sra sign-fills, lui passes src2.
REQ-023 reqN_op all-zero -> result 0, still a normal transaction; multi-hot op -> OR of selected results (not checked).
REQ-024 Requester may drop reqN_valid before grant; no transaction occurs and no state changes for that port.
REQ-025 Sustained contention with both slots drained every cycle -> grants strictly alternate 0,1,0,1.
REQ-026 busy = rsp0_valid | rsp1_valid.

Reset
REQ-027 resetn low -> immediately: both slots EMPTY, rspN_valid 0, rspN_result 0, reqN_ready 0, busy 0, last_grant = RR_RESET_LAST.
REQ-028 Reset mid-transaction discards pending results; no output or grant until the first rising edge after resetn high.

Verification
REQ-029 Single op: req0 add 0x7FFFFFFF+0x1, rsp0_ready 1 -> req0_ready in T, rsp0_valid at T+1 with 0x80000000, then low at T+2.
REQ-030 Tie after reset (RR_RESET_LAST=1): both valid, port0 slt 0xFFFFFFFF,0x1 and port1 sltu same operands -> port0 granted first (result 1), port1 next cycle (result 0).
REQ-031 Backpressure: rsp1_ready 0, port1 sra 0x80000000 by 4 -> rsp1_result 0xF8000000 held; second req1 stalled (req1_ready 0) until rsp1_ready 1, then accepted same cycle.
REQ-032 Back-to-back: port0 streams 4 adds with rsp0_ready 1, port1 idle -> one result per cycle, no bubbles.
REQ-033 Contention: both stream 8 ops, both drained -> grants alternate, results match ALU model per port in order.
REQ-034 Async reset: resetn low between clock edges with both slots FULL -> rsp0_valid, rsp1_valid, busy drop without clock edge; results 0.
